// File: rtl/matrix_key_scanner_pkg.sv
// Shared definitions for the 4x4 key matrix scanner: FSM state encodings,
// matrix geometry and small decode helpers.
package matrix_key_scanner_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StPressed  = 2'd2,
    StRelease  = 2'd3
  } key_state_e;

  localparam int unsigned Rows = 4;
  localparam int unsigned Cols = 4;
  localparam logic [Cols-1:0] NoKey = 4'hF;

  // Index of the lowest active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low_col(input logic [Cols-1:0] col);
    lowest_low_col = 2'd0;
    for (int i = Cols - 1; i >= 0; i--) begin
      if (!col[i]) lowest_low_col = 2'(i);
    end
  endfunction

  // Active-low one-hot row drive for row index r.
  function automatic logic [Rows-1:0] row_drive(input logic [1:0] r);
    row_drive = ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every CLK_DIV clocks.
// The count restarts at zero on synchronous reset.
module scan_tick_gen
  import matrix_key_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk_50M,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Divider counter, wraps after the tick cycle.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LastCnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/matrix_key_scanner.sv
// 4x4 active-low key matrix scanner: walks the rows on each scan tick,
// debounces the first low column found and reports one key code per press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module matrix_key_scanner
  import matrix_key_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned REPEAT_TICKS   = 500
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_TICKS);
  localparam logic [DbW-1:0] DbOne  = DbW'(1);

  logic            tick;
  logic [3:0]      col_meta_q, col_s_q;
  key_state_e      state_q, state_d;
  logic [1:0]      r_q, r_d;
  logic [1:0]      c_q, c_d;
  logic [DbW-1:0]  cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic [1:0]      det_col;
  logic            col_up;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS);
  logic [RepW-1:0] rep_q, rep_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_TICKS != 0);
`endif

  scan_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_50M(clk_50M),
    .rst    (rst),
    .tick   (tick)
  );

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      col_meta_q <= NoKey;
      col_s_q    <= NoKey;
    end else begin
      col_meta_q <= COL;
      col_s_q    <= col_meta_q;
    end
  end

  assign det_col = lowest_low_col(col_s_q);
  assign col_up  = col_s_q[c_q];

  // State, row index, latched key, counters and output registers.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= StScan;
      r_q     <= 2'd0;
      c_q     <= 2'd0;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Next-state logic; everything advances on tick cycles only.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (col_s_q == NoKey) begin
            r_d = r_q + 2'd1;
          end else begin
            c_d   = det_col;
            cnt_d = DbOne;
            if (DEBOUNCE_TICKS == 1) begin
              // A single agreeing tick is enough: accept on detection.
              state_d = StPressed;
              code_d  = {r_q, det_col};
              valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (!col_up) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DbLast) begin
              state_d = StPressed;
              code_d  = {r_q, c_q};
              valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end else begin
            state_d = StScan;
            r_d     = r_q + 2'd1;
          end
        end
        StPressed: begin
          if (col_up) begin
            cnt_d = DbOne;
            if (DEBOUNCE_TICKS == 1) begin
              state_d = StScan;
              r_d     = r_q + 2'd1;
            end else begin
              state_d = StRelease;
            end
          end else begin
`ifdef KEY_REPEAT_EN
            rep_d = rep_q + 1'b1;
            if (rep_d == RepLast) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end
`endif
          end
        end
        StRelease: begin
          if (col_up) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DbLast) begin
              state_d = StScan;
              r_d     = r_q + 2'd1;
            end
          end else begin
            // Release bounce: back to held without a new pulse.
            state_d = StPressed;
`ifdef KEY_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign ROW       = row_drive(r_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Bench for matrix_key_scanner: models the key matrix, predicts key events at
// scan-tick granularity and checks pulses through a scoreboard queue.
module tb_matrix_key_scanner;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;
  localparam int REP     = 5;

  logic        clk_50M = 1'b0;
  logic        rst     = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int vectors     = 0;
  int miscompares = 0;
  int n_pulses    = 0;

  // Reference state, one step per scan tick.
  int         m_row, m_phase, m_key, m_agree, m_rep;
  logic [3:0] m_code;
  logic [3:0] exp_q[$];

  always #5 clk_50M = ~clk_50M;

  matrix_key_scanner #(
    .CLK_DIV       (CLK_DIV),
    .DEBOUNCE_TICKS(DB),
    .REPEAT_TICKS  (REP)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .COL      (col),
    .ROW      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Matrix: a column reads low when a pressed key sits on a driven-low row.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && row[r] == 1'b0) col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every key_valid pulse must match a predicted event.
  always @(negedge clk_50M) begin
    if (key_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got code %0h, expected no pulse (t=%0t)", key_code, $time);
      end else begin
        check("pulse_code", key_code, exp_q.pop_front());
      end
    end
  end

  task automatic accept();
    m_phase = 2;
    m_code  = m_key[3:0];
    m_rep   = 0;
    exp_q.push_back(m_code);
  endtask

  task automatic next_row();
    m_phase = 0;
    m_row   = (m_row + 1) % 4;
  endtask

  // Behavioural model of one scan tick using the current key set.
  task automatic model_step();
    int hit;
    hit = -1;
    case (m_phase)
      0: begin
        for (int c = 3; c >= 0; c--) if (keys[m_row*4+c]) hit = c;
        if (hit < 0) begin
          m_row = (m_row + 1) % 4;
        end else begin
          m_key   = m_row * 4 + hit;
          m_agree = 1;
          if (m_agree >= DB) accept();
          else m_phase = 1;
        end
      end
      1: begin
        if (keys[m_key]) begin
          m_agree++;
          if (m_agree >= DB) accept();
        end else begin
          next_row();
        end
      end
      2: begin
        if (!keys[m_key]) begin
          m_agree = 1;
          if (m_agree >= DB) next_row();
          else m_phase = 3;
        end else begin
`ifdef KEY_REPEAT_EN
          m_rep++;
          if (m_rep == REP) begin
            exp_q.push_back(m_code);
            m_rep = 0;
          end
`endif
        end
      end
      default: begin
        if (!keys[m_key]) begin
          m_agree++;
          if (m_agree >= DB) next_row();
        end else begin
          m_phase = 2;
          m_rep   = 0;
        end
      end
    endcase
  endtask

  task automatic tick_step();
    logic [3:0] exp_row;
    repeat (CLK_DIV) @(posedge clk_50M);
    #1;
    check("pulse_missed", exp_q.size(), 0);
    model_step();
    exp_row = ~(4'b0001 << m_row);
    check("row", row, exp_row);
    check("held", key_held, (m_phase >= 2) ? 1 : 0);
    check("code", key_code, m_code);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk_50M);
    #1;
    check("reset_row", row, 4'b1110);
    check("reset_held", key_held, 0);
    check("reset_code", key_code, 0);
    check("reset_valid", key_valid, 0);
    rst     = 1'b0;
    m_row   = 0;
    m_phase = 0;
    m_code  = 4'd0;
    m_agree = 0;
    m_rep   = 0;
  endtask

  task automatic run_until_pressed(input string name, input int max_ticks);
    for (int i = 0; i < max_ticks && m_phase != 2; i++) tick_step();
    check(name, key_held, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [4];
    int p0;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    // Idle scan with no keys.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick_step();
      check("idle_row_seq", row, seq[i%4]);
    end

    // Single key (2,1): one pulse, frozen row, then debounced release.
    do_reset();
    keys = 16'h0200;
    run_until_pressed("press_2_1", 40);
    check("code_2_1", key_code, 4'd9);
    check("frozen_row", row, 4'b1011);
    for (int i = 0; i < 3; i++) tick_step();
    keys = '0;
    for (int i = 0; i < 3; i++) tick_step();
    check("release_held", key_held, 0);
    check("release_row", row, 4'b0111);

    // Press bounce on (1,3), then release bounce while held.
    do_reset();
    for (int i = 0; i < 8 && m_row != 1; i++) tick_step();
    keys = 16'h0080;
    tick_step();
    keys = '0;
    tick_step();
    check("bounce_press_held", key_held, 0);
    keys = 16'h0080;
    run_until_pressed("press_1_3", 40);
    tick_step();
    p0 = n_pulses;
    keys = '0;
    repeat (2) tick_step();
    keys = 16'h0080;
    repeat (2) tick_step();
    check("bounce_release_held", key_held, 1);
    check("bounce_release_pulses", n_pulses - p0, 0);

    // Two keys on row 0: lowest column first, the other on the next visit.
    do_reset();
    keys = 16'h0005;
    run_until_pressed("press_0_0", 40);
    check("code_0_0", key_code, 4'd0);
    keys = 16'h0004;
    for (int i = 0; i < 40 && !(m_phase == 2 && m_code == 4'd2); i++) tick_step();
    check("code_0_2", key_code, 4'd2);

    // Reset while (3,3) is held, then re-detection.
    do_reset();
    keys = 16'h8000;
    run_until_pressed("press_3_3", 40);
    do_reset();
    run_until_pressed("redetect_3_3", 40);
    check("code_3_3", key_code, 4'd15);

    // Long hold of (1,0): auto-repeat only when enabled.
    do_reset();
    keys = '0;
    tick_step();
    @(negedge clk_50M);
    p0 = n_pulses;
    keys = 16'h0010;
    run_until_pressed("press_1_0", 40);
    for (int i = 0; i < 20; i++) tick_step();
    @(negedge clk_50M);
    #1;
`ifdef KEY_REPEAT_EN
    check("repeat_pulses", n_pulses - p0, 5);
`else
    check("repeat_pulses", n_pulses - p0, 1);
`endif
    check("repeat_code", key_code, 4'd4);

    // Randomised key activity against the model.
    do_reset();
    keys = '0;
    for (int i = 0; i < 300; i++) begin
      tick_step();
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: keys = '0;
          1: keys = 16'(1) << $urandom_range(0, 15);
          default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
    end
    keys = '0;
    repeat (12) tick_step();

    @(negedge clk_50M);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
